wb_trace_buffer: RTL
====================

Name: wb_trace_buffer

Overview:
Downstream consumer of the pipelined datapath's write-back outputs (WriteData, ProgramCount, RegWriteCommand). Captures one {PC, data} record per register-file write into a first-word-fall-through FIFO. A slower board-level display/readout controller drains the FIFO through a valid/ready handshake. Counts and flags writes lost to a full buffer, so the trace can be inspected without slowing the core.

Parameters:
DEPTH, 16, number of trace entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH); pointer width
DATA_W, 32, width of the PC and data fields

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
WriteData  input  DATA_W  write-back data from the datapath
ProgramCount  input  DATA_W  PC value paired with the write
RegWriteCommand  input  1  high for one cycle per register-file write; a capture request
Freeze  input  1  high = ignore capture requests; drain still permitted
OutReady  input  1  consumer accepts the head entry this cycle
OutValid  output  1  head entry present
OutPC  output  DATA_W  PC field of head entry
OutData  output  DATA_W  data field of head entry
Count  output  ADDR_W+1  current occupancy, 0..DEPTH
Overflow  output  1  sticky; set on first dropped capture
DropCount  output  16  number of dropped captures, saturating

Behaviour:
- Reset (sync, Reset=1 at rising edge): wr_ptr=0, rd_ptr=0, Count=0, OutValid=0, Overflow=0, DropCount=0. OutPC/OutData read 0 while empty. Storage array is not cleared.
- Reset overrides everything, including a push or pop in the same cycle. Reset mid-drain discards all entries.
- push = RegWriteCommand & ~Freeze. pop = OutValid & OutReady.
- OutValid = (Count != 0), driven from registered Count.
- OutPC/OutData = mem[rd_ptr]: FWFT, combinational read of registered storage.
- Latency: a push at edge N makes the entry visible on OutValid/OutPC/OutData after edge N (next cycle). There is no same-cycle bypass.
- Push, not full: mem[wr_ptr] <= {ProgramCount, WriteData}; wr_ptr+1, wrapping mod DEPTH.
- Pop: rd_ptr+1, wrapping mod DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Full (Count==DEPTH), push with no pop: entry dropped, Count unchanged, Overflow<=1, DropCount+1 saturating at 16'hFFFF.
- Full, push with pop: both accepted, no drop; the freed slot is reused.
- Empty, push with OutReady=1: pop is not qualified because OutValid=0. Push accepted; Count becomes 1.
- OutReady while empty: no effect; pointers hold.
- Freeze=1 suppresses pushes entirely. Suppressed requests are neither stored nor counted as drops.
- Overflow and DropCount clear only on Reset.
- Pointers carry no extra wrap bit. Full/empty are decided solely from Count.

Optional Feature:
WB_TRACE_TIMESTAMP_EN
- Defined: adds a 32-bit free-running cycle counter (0 on Reset, +1 every cycle, wraps). Each entry stores the counter value at the push edge, and a port OutStamp (output, 32) presents the head entry's stamp, FWFT like OutPC. Storage widens by 32 bits per entry.
- Undefined: no counter, no OutStamp port; storage is 2*DATA_W per entry. All other behaviour is identical.

Test Plan:
1. Reset, then pulse RegWriteCommand with PC=0x00000010, Data=0x0000002A, OutReady=0 -> next cycle OutValid=1, OutPC=0x10, OutData=0x2A, Count=1.
2. Push 16 distinct records (Data=1..16), then 3 more with OutReady=0 -> Count=16, Overflow=1, DropCount=3; drain shows Data 1..16 in order, then OutValid=0, Count=0.
3. Fill to 16, then hold RegWriteCommand=1 and OutReady=1 for 5 cycles -> Count stays 16, DropCount=0, the 5 new records appear after the original 16 (pointer wrap verified).
4. Empty buffer, RegWriteCommand=1 and OutReady=1 in the same cycle -> Count=1 next cycle, record not lost, OutValid=1.
5. Freeze=1, 4 write pulses -> Count=0, DropCount=0, Overflow=0. Then Freeze=0 with 1 pulse -> Count=1.
6. Buffer holding 5 entries with Overflow=1, assert Reset for one cycle while OutReady=1 and RegWriteCommand=1 -> Count=0, OutValid=0, Overflow=0, DropCount=0; with WB_TRACE_TIMESTAMP_EN, the first post-reset push at cycle 3 reads OutStamp=3.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Write-back trace capture: one {PC, data} record per register-file write, held in a FWFT FIFO.
// Optional WB_TRACE_TIMESTAMP_EN adds a free-running cycle stamp to every record (OutStamp port).
module wb_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ProgramCount,
    input  logic              RegWriteCommand,
    input  logic              Freeze,
    input  logic              OutReady,
    output logic              OutValid,
    output logic [DATA_W-1:0] OutPC,
    output logic [DATA_W-1:0] OutData,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow,
    output logic [15:0]       DropCount
`ifdef WB_TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]       OutStamp
`endif
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] memPC   [DEPTH];
    logic [DATA_W-1:0] memData [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic              full;
    logic              push;
    logic              pop;
    logic              doWrite;
    logic              drop;

    assign full     = (Count == FULL_COUNT);
    assign OutValid = (Count != '0);
    assign push     = RegWriteCommand & ~Freeze;
    assign pop      = OutValid & OutReady;
    // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
    assign doWrite  = push & (~full | pop);
    assign drop     = push & full & ~pop;

    assign OutPC   = OutValid ? memPC[rdPtr]   : '0;
    assign OutData = OutValid ? memData[rdPtr] : '0;

    // Storage is deliberately left uncleared by Reset.
    always_ff @(posedge Clk) begin
        if (doWrite && !Reset) begin
            memPC[wrPtr]   <= ProgramCount;
            memData[wrPtr] <= WriteData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            Count     <= '0;
            Overflow  <= 1'b0;
            DropCount <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + 1'b1;
            if (pop)     rdPtr <= rdPtr + 1'b1;
            case ({doWrite, pop})
                2'b10:   Count <= Count + ONE_COUNT;
                2'b01:   Count <= Count - ONE_COUNT;
                default: Count <= Count;
            endcase
            if (drop) begin
                Overflow <= 1'b1;
                if (DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
            end
        end
    end

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] cycleCount;
    logic [31:0] memStamp [DEPTH];

    always_ff @(posedge Clk) begin
        if (Reset) cycleCount <= '0;
        else       cycleCount <= cycleCount + 32'd1;
    end

    always_ff @(posedge Clk) begin
        if (doWrite && !Reset) memStamp[wrPtr] <= cycleCount;
    end

    assign OutStamp = OutValid ? memStamp[rdPtr] : '0;
`endif

endmodule
